// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one multiplier bit per clock.
// Signed mode multiplies magnitudes and applies the sign on the final edge,
// so a single unsigned datapath covers both modes.
module seq_shift_add_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               signed_mode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] mcand_q;
  logic [CW-1:0]    count_q;
  logic             neg_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    product_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;
  logic             neg_d;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    product_d;
  logic             last_iter;

  // Operand magnitudes at capture time, and next accumulator / signed result
  always_comb begin
    a_mag_d   = (signed_mode_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag_d   = (signed_mode_i && b_i[WIDTH-1]) ? -b_i : b_i;
    neg_d     = signed_mode_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    addend    = {{WIDTH{1'b0}}, mplier_q} << count_q;
    acc_d     = mcand_q[0] ? (acc_q + addend) : acc_q;
    // A zero magnitude negates to zero, so no -0 artefact can appear
    product_d = neg_q ? -acc_d : acc_d;
    last_iter = (count_q == CW'(WIDTH - 1));
  end

  // Control FSM and datapath with registered busy/done/product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mplier_q  <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            mplier_q <= a_mag_d;
            mcand_q  <= b_mag_d;
            neg_q    <= neg_d;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q >> 1;
          count_q <= count_q + 1'b1;
          if (last_iter) begin
            product_q <= product_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult (WIDTH=8): directed spec cases, back-to-back
// handshake, mid-run reset and random operands against a reference multiply.
module tb_seq_shift_add_mult;
  localparam int W = 8;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic          signed_mode_i;
  logic [W-1:0]  a_i;
  logic [W-1:0]  b_i;
  logic          busy_o;
  logic          done_o;
  logic [2*W-1:0] product_o;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .signed_mode_i (signed_mode_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .product_o     (product_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic m);
    logic signed [2*W-1:0] sa, sb;
    logic [2*W-1:0] r;
    if (m) begin
      sa = $signed({{W{a[W-1]}}, a});
      sb = $signed({{W{b[W-1]}}, b});
      r  = sa * sb;
    end else begin
      r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = 8'h00;
      1: v = 8'h80;
      2: v = 8'hFF;
      3: v = 8'h7F;
      4: v = 8'h01;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  // One full operation started from IDLE; operands and start are disturbed during RUN
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input logic [2*W-1:0] exp, input string tag);
    logic [2*W-1:0] prev;
    int cyc;
    int busy_cnt;
    logic hold_ok;
    @(negedge clk);
    a_i = a; b_i = b; signed_mode_i = m; start_i = 1'b1;
    exp_q.push_back(exp);
    prev = product_o;
    @(posedge clk); #1;
    start_i = 1'b0;
    a_i = ~a; b_i = b ^ 8'h5A; signed_mode_i = ~m;
    cyc = 0; busy_cnt = 0; hold_ok = 1'b1;
    while (!done_o && cyc < 3 * W) begin
      if (busy_o) busy_cnt++;
      if (product_o !== prev) hold_ok = 1'b0;
      start_i = (cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    check({tag, "_latency"}, cyc, W);
    check({tag, "_busy_cycles"}, busy_cnt, W);
    check({tag, "_prod_hold"}, hold_ok, 1);
    check({tag, "_busy_at_done"}, busy_o, 0);
    check({tag, "_product"}, product_o, exp_q.pop_front());
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done_o, 0);
  endtask

  initial begin
    logic [W-1:0] va[4];
    logic [W-1:0] vb[4];
    logic         vm[4];
    int cyc;

    start_i = 0; signed_mode_i = 0; a_i = '0; b_i = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #5;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_product", product_o, 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases with known results
    do_op(8'd200, 8'd150, 1'b0, 16'd30000, "u200x150");
    do_op(8'hF6,  8'd7,   1'b1, 16'hFFBA,  "s_m10x7");
    do_op(8'h80,  8'h80,  1'b1, 16'h4000,  "s_minxmin");
    do_op(8'hFF,  8'hFF,  1'b0, 16'hFE01,  "u_ffxff");
    do_op(8'hFF,  8'hFF,  1'b1, 16'h0001,  "s_ffxff");
    do_op(8'h00,  8'h80,  1'b1, 16'h0000,  "s_zero");
    do_op(8'h7F,  8'h80,  1'b1, 16'hC080,  "s_maxxmin");

    // Back-to-back with start held high and operands changing during RUN
    va[0] = 8'd10;  vb[0] = 8'd20;  vm[0] = 1'b0;
    va[1] = 8'h80;  vb[1] = 8'h7F;  vm[1] = 1'b1;
    va[2] = 8'hFE;  vb[2] = 8'h03;  vm[2] = 1'b1;
    va[3] = 8'hFE;  vb[3] = 8'h03;  vm[3] = 1'b0;
    @(negedge clk);
    a_i = va[0]; b_i = vb[0]; signed_mode_i = vm[0]; start_i = 1'b1;
    exp_q.push_back(ref_mul(va[0], vb[0], vm[0]));
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      check("b2b_busy", busy_o, 1);
      a_i = 8'($urandom); b_i = 8'($urandom); signed_mode_i = 1'($urandom);
      cyc = 0;
      while (!done_o && cyc < 3 * W) begin
        @(posedge clk); #1;
        cyc++;
        a_i = 8'($urandom); b_i = 8'($urandom); signed_mode_i = 1'($urandom);
      end
      check("b2b_latency", cyc, W);
      check("b2b_product", product_o, exp_q.pop_front());
      if (k < 3) begin
        a_i = va[k+1]; b_i = vb[k+1]; signed_mode_i = vm[k+1];
        exp_q.push_back(ref_mul(va[k+1], vb[k+1], vm[k+1]));
        @(posedge clk); #1;
      end else begin
        start_i = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("b2b_idle_busy", busy_o, 0);
    check("b2b_idle_done", done_o, 0);

    // Reset during iteration 4 aborts the operation
    @(negedge clk);
    a_i = 8'd3; b_i = 8'd5; signed_mode_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_product", product_o, 0);
    @(negedge clk); rst_n = 1'b1;
    do_op(8'd2, 8'd3, 1'b0, 16'd6, "post_rst");

    // Random operands including extremes and zero
    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] ra, rb;
      logic rm;
      ra = pick(); rb = pick(); rm = 1'($urandom);
      do_op(ra, rb, rm, ref_mul(ra, rb, rm), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
